// File: rtl/imu_frame_pkg.sv
// Shared constants, register offsets and parser state encoding for the IMU frame decoder.
package imu_frame_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'h55;
  localparam logic [7:0] TYPE_BASE = 8'h50;
  localparam int         FRAME_LEN = 11;

  localparam logic [7:0] REG_CTRL     = 8'h00;
  localparam logic [7:0] REG_STATUS   = 8'h04;
  localparam logic [7:0] REG_FRAME_OK = 8'h08;
  localparam logic [7:0] REG_CSUM_ERR = 8'h0C;
  localparam logic [7:0] REG_IRQ_MASK = 8'h10;
  localparam logic [7:0] REG_TSTAMP   = 8'h14;
  localparam logic [7:0] REG_PAYLOAD  = 8'h20;

  typedef enum logic [1:0] {IDLE, TYPE, DATA, CSUM} parser_state_t;

endpackage

// File: rtl/axi_imu_frame_decoder_if.sv
// AXI4-Lite bundle for the IMU frame decoder register port.
interface axi_imu_frame_decoder_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid, awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid, wready;
  logic [1:0]          bresp;
  logic                bvalid, bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid, arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid, rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_imu_frame_decoder_uart_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser; one-cycle rx_valid or frame_err per byte.
module imu_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic [2:0]    sync;   // [1:0] synchroniser, [2] previous synchronised level
  logic          rxd_s;

  assign rxd_s   = sync[1];
  assign rx_byte = shreg;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= 3'b111;
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      sync    <= {sync[1:0], rxd};
      state   <= state_d;
      cnt     <= cnt_d;
      bit_idx <= bit_idx_d;
      shreg   <= shreg_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt + CW'(1);
    bit_idx_d = bit_idx;
    shreg_d   = shreg;
    rx_valid  = 1'b0;
    frame_err = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_d = '0;
        if (sync[2] && !rxd_s) state_d = RX_START;
      end
      RX_START: if (cnt == HALF) begin
        cnt_d     = '0;
        bit_idx_d = '0;
        state_d   = rxd_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (cnt == FULL) begin
        cnt_d     = '0;
        shreg_d   = {rxd_s, shreg[7:1]};
        bit_idx_d = bit_idx + 3'd1;
        if (bit_idx == 3'd7) state_d = RX_STOP;
      end
      RX_STOP: if (cnt == FULL) begin
        cnt_d     = '0;
        state_d   = RX_IDLE;
        rx_valid  = rxd_s;
        frame_err = !rxd_s;
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/axi_imu_frame_decoder.sv
// WT931-style IMU frame decoder with AXI4-Lite register file.
// Optional frame timestamp register enabled by defining IMU_FRAME_TIMESTAMP_EN.
module axi_imu_frame_decoder
  import imu_frame_pkg::*;
#(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 7,
  parameter int NUM_TYPES            = 8,
  parameter int CLKS_PER_BIT         = 868,
  parameter int TIMEOUT_CYCLES       = 20000
) (
  input  logic                    s00_axi_aclk,
  input  logic                    s00_axi_aresetn,
  input  logic                    uart_rxd,
  output logic                    irq,
  axi_imu_frame_decoder_if.slave  s00_axi
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic clk, rst_n;
  assign clk   = s00_axi_aclk;
  assign rst_n = s00_axi_aresetn;

  logic       rx_valid, frame_err;
  logic [7:0] rx_byte;

  imu_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst_n(rst_n), .rxd(uart_rxd),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .frame_err(frame_err)
  );

  // ---------------- parser ----------------
  parser_state_t state, state_d;
  logic [2:0]    data_cnt;
  logic [7:0]    sum, type_byte, type_idx;
  logic [63:0]   data_sr;
  logic [TW-1:0] timer;
  logic          timeout, commit, csum_bad, ctrl_en;

  assign timeout  = (timer == TW'(TIMEOUT_CYCLES));
  assign type_idx = type_byte - TYPE_BASE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data_cnt  <= '0;
      sum       <= '0;
      type_byte <= '0;
      data_sr   <= '0;
      timer     <= '0;
    end else begin
      state <= state_d;
      if (rx_valid || state == IDLE) timer <= '0;
      else if (!timeout)             timer <= timer + TW'(1);
      if (rx_valid) begin
        sum <= (state == IDLE) ? rx_byte : sum + rx_byte;
        if (state == TYPE) type_byte <= rx_byte;
        if (state == DATA) begin
          data_sr  <= {rx_byte, data_sr[63:8]};  // b2 ends in the low byte
          data_cnt <= data_cnt + 3'd1;
        end else begin
          data_cnt <= '0;
        end
      end
    end
  end

  always_comb begin
    state_d  = state;
    commit   = 1'b0;
    csum_bad = 1'b0;
    if (!ctrl_en || frame_err || (timeout && state != IDLE)) begin
      state_d = IDLE;
    end else if (rx_valid) begin
      unique case (state)
        IDLE: if (rx_byte == HDR_BYTE) state_d = TYPE;
        TYPE: state_d = DATA;
        DATA: if (data_cnt == 3'd7) state_d = CSUM;
        CSUM: begin
          state_d = IDLE;
          if (rx_byte == sum) commit = (type_idx < 8'(NUM_TYPES));
          else                csum_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- register file ----------------
  logic [NUM_TYPES-1:0] status, set_mask, w1c_mask;
  logic [31:0] frame_ok, csum_err, irq_mask, shadow, tstamp_rd;
  logic [31:0] word0 [NUM_TYPES];
  logic [31:0] word1 [NUM_TYPES];
  logic [31:0] wmask, wbits, rd_data, w0_sel, w1_sel;
  logic [7:0]  waddr, raddr, pay_off;
  logic        aw_rdy, b_vld, ar_rdy, r_vld, wr_en, rd_en, clr, pay_hit;
  logic [31:0] r_data;

  assign s00_axi.awready = aw_rdy;
  assign s00_axi.wready  = aw_rdy;
  assign s00_axi.bvalid  = b_vld;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = ar_rdy;
  assign s00_axi.rvalid  = r_vld;
  assign s00_axi.rdata   = r_data;
  assign s00_axi.rresp   = 2'b00;

  assign wr_en = s00_axi.awvalid && aw_rdy;
  assign rd_en = s00_axi.arvalid && ar_rdy;
  assign waddr = 8'(s00_axi.awaddr) & 8'hFC;
  assign raddr = 8'(s00_axi.araddr) & 8'hFC;
  assign wmask = {{8{s00_axi.wstrb[3]}}, {8{s00_axi.wstrb[2]}},
                  {8{s00_axi.wstrb[1]}}, {8{s00_axi.wstrb[0]}}};
  assign wbits = s00_axi.wdata & wmask;
  assign clr   = wr_en && waddr == REG_CTRL && wbits[1];
  assign irq   = |(status & irq_mask[NUM_TYPES-1:0]);
  assign pay_off  = raddr - REG_PAYLOAD;
  assign w1c_mask = (wr_en && waddr == REG_STATUS) ? wbits[NUM_TYPES-1:0] : '0;

  logic unused_ok;
  assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot, wbits, pay_off[1:0]};

  always_comb begin
    set_mask = '0;
    w0_sel   = '0;
    w1_sel   = '0;
    pay_hit  = 1'b0;
    for (int k = 0; k < NUM_TYPES; k++) begin
      set_mask[k] = commit && type_idx == 8'(k);
      if (raddr >= REG_PAYLOAD && pay_off[7:3] == 5'(k)) begin
        pay_hit = 1'b1;
        w0_sel  = word0[k];
        w1_sel  = word1[k];
      end
    end
    rd_data = '0;
    case (raddr)
      REG_CTRL:     rd_data = {31'b0, ctrl_en};
      REG_STATUS:   rd_data = 32'(status);
      REG_FRAME_OK: rd_data = frame_ok;
      REG_CSUM_ERR: rd_data = csum_err;
      REG_IRQ_MASK: rd_data = irq_mask;
      REG_TSTAMP:   rd_data = tstamp_rd;
      default:      if (pay_hit) rd_data = pay_off[2] ? shadow : w0_sel;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_rdy   <= 1'b0;
      b_vld    <= 1'b0;
      ar_rdy   <= 1'b0;
      r_vld    <= 1'b0;
      r_data   <= '0;
      ctrl_en  <= 1'b0;
      status   <= '0;
      frame_ok <= '0;
      csum_err <= '0;
      irq_mask <= '0;
      shadow   <= '0;
      // NOTE: the payload store is reset because software may read it before any frame arrives.
      for (int k = 0; k < NUM_TYPES; k++) begin
        word0[k] <= '0;
        word1[k] <= '0;
      end
    end else begin
      aw_rdy <= s00_axi.awvalid && s00_axi.wvalid && !b_vld && !aw_rdy;
      ar_rdy <= s00_axi.arvalid && !r_vld && !ar_rdy;
      if (wr_en)                b_vld <= 1'b1;
      else if (s00_axi.bready)  b_vld <= 1'b0;
      if (rd_en) begin
        r_vld  <= 1'b1;
        r_data <= rd_data;
        if (pay_hit && !pay_off[2]) shadow <= w1_sel;  // pre-commit WORD1 on a same-cycle commit
      end else if (s00_axi.rready) begin
        r_vld <= 1'b0;
      end

      if (wr_en && waddr == REG_CTRL && s00_axi.wstrb[0]) ctrl_en <= s00_axi.wdata[0];
      if (wr_en && waddr == REG_IRQ_MASK) irq_mask <= (irq_mask & ~wmask) | wbits;
      status <= (status & ~w1c_mask) | set_mask;

      if (clr)                          frame_ok <= '0;
      else if (commit && ~&frame_ok)    frame_ok <= frame_ok + 32'd1;
      if (clr)                          csum_err <= '0;
      else if (csum_bad && ~&csum_err)  csum_err <= csum_err + 32'd1;

      for (int k = 0; k < NUM_TYPES; k++) begin
        if (set_mask[k]) begin
          word0[k] <= data_sr[31:0];
          word1[k] <= data_sr[63:32];
        end
      end
    end
  end

`ifdef IMU_FRAME_TIMESTAMP_EN
  logic [31:0] cycle_cnt, tstamp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      tstamp    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (commit) tstamp <= cycle_cnt;
    end
  end
  assign tstamp_rd = tstamp;
`else
  assign tstamp_rd = '0;
`endif

endmodule

// File: tb/tb_axi_imu_frame_decoder.sv
// Scoreboard bench for axi_imu_frame_decoder: reads push expectations, a monitor checks R beats.
module tb_axi_imu_frame_decoder;
  localparam int CPB = 8;
  localparam int TMO = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_rxd = 1'b1;
  logic irq;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  axi_imu_frame_decoder_if #(.ADDR_W(7), .DATA_W(32)) axi ();

  axi_imu_frame_decoder #(
    .C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(7), .NUM_TYPES(8),
    .CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .uart_rxd(uart_rxd),
    .irq(irq), .s00_axi(axi)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every R beat is compared with the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && axi.rvalid && axi.rready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_r: got 0x%08h with nothing expected", axi.rdata);
      end else begin
        check(name_q.pop_front(), axi.rdata, exp_q.pop_front());
      end
    end
  end

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
    int n;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk); #1;
    axi.araddr  = a[6:0];
    axi.arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.arready && n < 50);
    if (!axi.arready) check({name, "_ar_timeout"}, 32'(axi.arready), 32'd1);
    @(posedge clk); #1;
    axi.arvalid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      check({name, "_r_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    axi.awaddr  = a[6:0];
    axi.wdata   = d;
    axi.wstrb   = 4'hF;
    axi.awvalid = 1'b1;
    axi.wvalid  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!axi.awready && n < 50);
    if (!axi.awready) check("aw_timeout", 32'(axi.awready), 32'd1);
    @(posedge clk); #1;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    n = 0;
    while (!axi.bvalid && n < 50) begin @(negedge clk); n++; end
    if (!axi.bvalid) check("b_timeout", 32'(axi.bvalid), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic uart_bit(input logic v);
    uart_rxd = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic uart_byte(input logic [7:0] b, input logic stop);
    uart_bit(1'b0);
    for (int i = 0; i < 8; i++) uart_bit(b[i]);
    uart_bit(stop);
    uart_bit(1'b1);
    uart_bit(1'b1);
  endtask

  // Bytes are sent most-significant first: f[87:80] is the 0x55 header.
  task automatic uart_frame(input logic [87:0] f);
    for (int i = 10; i >= 0; i--) uart_byte(f[i*8 +: 8], 1'b1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  localparam logic [87:0] FRAME_53    = 88'h55_53_01_02_03_04_05_06_07_08_CC;
  localparam logic [87:0] FRAME_53_BAD = 88'h55_53_01_02_03_04_05_06_07_08_CD;
  localparam logic [87:0] FRAME_50    = 88'h55_50_11_22_33_44_55_66_77_88_09;
  localparam logic [87:0] FRAME_5F    = 88'h55_5F_01_02_03_04_05_06_07_08_D8;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0;  axi.wstrb = '0;  axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;

    repeat (5) @(posedge clk);
    check("reset_handshake", {28'b0, axi.awready, axi.bvalid, axi.arready, axi.rvalid}, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    rd(8'h00, 32'h0, "rst_ctrl");
    rd(8'h04, 32'h0, "rst_status");
    rd(8'h08, 32'h0, "rst_frame_ok");
    rd(8'h0C, 32'h0, "rst_csum_err");
    rd(8'h10, 32'h0, "rst_irq_mask");
    rd(8'h14, 32'h0, "rst_tstamp");
    for (int k = 0; k < 16; k++) begin
      logic [7:0] a;
      a = 8'h20 + 8'(4 * k);
      rd(a, 32'h0, $sformatf("rst_payload_%02h", a));
    end

    wr(8'h00, 32'h1);
    rd(8'h00, 32'h1, "ctrl_en_rb");

    uart_frame(FRAME_53);
    rd(8'h38, 32'h04030201, "t3_word0");
    rd(8'h3C, 32'h08070605, "t3_word1");
    rd(8'h04, 32'h08, "status_t3");
    rd(8'h08, 32'd1, "frame_ok_1");

    uart_frame(FRAME_53_BAD);
    rd(8'h0C, 32'd1, "csum_err_1");
    rd(8'h04, 32'h08, "status_after_bad");
    rd(8'h08, 32'd1, "frame_ok_after_bad");
    rd(8'h38, 32'h04030201, "t3_word0_after_bad");

    uart_frame(FRAME_50);
    rd(8'h20, 32'h44332211, "t0_word0");
    rd(8'h24, 32'h88776655, "t0_word1");
    rd(8'h04, 32'h09, "status_t0_t3");
    rd(8'h08, 32'd2, "frame_ok_2");
    rd(8'h38, 32'h04030201, "t3_word0_again");
    rd(8'h24, 32'h08070605, "shared_shadow");

    for (int i = 0; i < 5; i++) uart_byte(FRAME_53[87 - 8*i -: 8], 1'b1);
    repeat (TMO + 10) @(posedge clk);
    #1;
    uart_frame(FRAME_53);
    rd(8'h08, 32'd3, "frame_ok_after_timeout");
    rd(8'h0C, 32'd1, "csum_err_after_timeout");

    uart_frame(FRAME_5F);
    rd(8'h08, 32'd3, "frame_ok_type_5f");
    rd(8'h0C, 32'd1, "csum_err_type_5f");
    rd(8'h04, 32'h09, "status_type_5f");

    for (int i = 0; i < 11; i++) uart_byte(FRAME_53[87 - 8*i -: 8], (i == 4) ? 1'b0 : 1'b1);
    repeat (20) @(posedge clk);
    #1;
    rd(8'h08, 32'd3, "frame_ok_after_ferr");
    rd(8'h0C, 32'd1, "csum_err_after_ferr");

    wr(8'h04, 32'hFF);
    rd(8'h04, 32'h0, "status_w1c_all");
    wr(8'h10, 32'h08);
    rd(8'h10, 32'h08, "irq_mask_rb");
    check("irq_masked_idle", 32'(irq), 32'd0);
    uart_frame(FRAME_53);
    check("irq_on_frame", 32'(irq), 32'd1);
    rd(8'h04, 32'h08, "status_irq_frame");
    rd(8'h08, 32'd4, "frame_ok_4");
    rd(8'h0C, 32'd1, "csum_err_still_1");
    wr(8'h04, 32'h08);
    check("irq_after_w1c", 32'(irq), 32'd0);
    wr(8'h00, 32'h3);
    rd(8'h08, 32'd0, "frame_ok_cleared");
    rd(8'h0C, 32'd0, "csum_err_cleared");
    rd(8'h00, 32'h1, "ctrl_clr_selfclear");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
